// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM command arbiter: command opcodes, FSM states and
// the burst-length clamp.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_REF  = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_BUSY  = 2'b10
  } arb_state_e;

  function automatic int clamp_len(input int len, input int max_burst);
    return (len > max_burst) ? max_burst : len;
  endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Auto-refresh interval timer: raises refresh_pending every REF_CYCLES cycles of
// init_done, and latches a sticky overrun when an interval expires unserved.
module sdram_ref_timer #(
  parameter int REF_CYCLES = 781
) (
  input  logic clk_ref,
  input  logic rst_n,
  input  logic init_done_i,
  input  logic ref_grant_i,
  output logic ref_pending_o,
  output logic ref_overrun_o
);

  localparam int CNT_W = $clog2(REF_CYCLES > 1 ? REF_CYCLES : 2);

  logic [CNT_W-1:0] cnt_q;
  logic             pending_q;
  logic             overrun_q;
  logic             wrap;

  assign wrap = init_done_i && (cnt_q == CNT_W'(REF_CYCLES - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else if (!init_done_i) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      // A fresh interval expiring wins over a grant of the previous one.
      if (wrap)             pending_q <= 1'b1;
      else if (ref_grant_i) pending_q <= 1'b0;
      if (wrap && pending_q && !ref_grant_i) overrun_q <= 1'b1;
    end
  end

  assign ref_pending_o = pending_q;
  assign ref_overrun_o = overrun_q;

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// Arbitrates refresh, write and read bursts into one SDRAM engine command at a time.
// Define SDRAM_ARB_RR_EN to break write/read ties round-robin instead of write-first.
module sdram_cmd_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int LEN_W      = 10,
  parameter int MAX_BURST  = 512,
  parameter int REF_CYCLES = 781
) (
  input  logic              clk_ref,
  input  logic              rst_n,
  input  logic              init_done_i,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [LEN_W-1:0]  wr_len_i,
  output logic              wr_ack_o,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [LEN_W-1:0]  rd_len_i,
  output logic              rd_ack_o,
  output logic              cmd_valid_o,
  output logic [1:0]        cmd_op_o,
  output logic [ADDR_W-1:0] cmd_addr_o,
  output logic [LEN_W-1:0]  cmd_len_o,
  input  logic              cmd_ready_i,
  input  logic              data_beat_i,
  input  logic              cmd_done_i,
  output logic              ref_overrun_o
);

  arb_state_e        state_q;
  cmd_op_e           op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_cnt_q;
  logic              valid_q;

  logic              ref_pending;
  logic              ref_grant;
  logic              wr_ok;
  logic              rd_ok;
  logic              pick_wr;
  logic              pick_rd;
  logic              beat_ok;

  cmd_op_e           grant_op_d;
  logic [ADDR_W-1:0] grant_addr_d;
  logic [LEN_W-1:0]  grant_len_d;

  // Zero-length bursts are not requests at all.
  assign wr_ok = wr_req_i && (wr_len_i != '0);
  assign rd_ok = rd_req_i && (rd_len_i != '0);

`ifdef SDRAM_ARB_RR_EN
  logic last_rd_q;

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      last_rd_q <= 1'b1;
    end else if (state_q == ST_IDLE && init_done_i && !ref_pending && (wr_ok || rd_ok)) begin
      last_rd_q <= pick_rd;
    end
  end

  assign pick_wr = wr_ok && !(rd_ok && !last_rd_q);
`else
  assign pick_wr = wr_ok;
`endif
  assign pick_rd = rd_ok && !pick_wr;

  // NOTE: every variable gets a default before the priority chain so the
  // block stays purely combinational and no latch is inferred.
  always_comb begin
    grant_op_d   = OP_NONE;
    grant_addr_d = '0;
    grant_len_d  = '0;
    if (ref_pending) begin
      grant_op_d = OP_REF;
    end else if (pick_wr) begin
      grant_op_d   = OP_WR;
      grant_addr_d = wr_addr_i;
      grant_len_d  = LEN_W'(clamp_len(int'(wr_len_i), MAX_BURST));
    end else if (pick_rd) begin
      grant_op_d   = OP_RD;
      grant_addr_d = rd_addr_i;
      grant_len_d  = LEN_W'(clamp_len(int'(rd_len_i), MAX_BURST));
    end
  end

  assign ref_grant = (state_q == ST_IDLE) && init_done_i && ref_pending;

  sdram_ref_timer #(
    .REF_CYCLES (REF_CYCLES)
  ) u_ref_timer (
    .clk_ref       (clk_ref),
    .rst_n         (rst_n),
    .init_done_i   (init_done_i),
    .ref_grant_i   (ref_grant),
    .ref_pending_o (ref_pending),
    .ref_overrun_o (ref_overrun_o)
  );

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_NONE;
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      valid_q    <= 1'b0;
    end else if (!init_done_i) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_NONE;
      beat_cnt_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_op_d != OP_NONE) begin
            state_q <= ST_ISSUE;
            valid_q <= 1'b1;
            op_q    <= grant_op_d;
            addr_q  <= grant_addr_d;
            len_q   <= grant_len_d;
          end
        end
        ST_ISSUE: begin
          if (cmd_ready_i) begin
            state_q    <= ST_BUSY;
            valid_q    <= 1'b0;
            beat_cnt_q <= '0;
          end
        end
        ST_BUSY: begin
          if (beat_ok) beat_cnt_q <= beat_cnt_q + 1'b1;
          if (cmd_done_i) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Acks follow data_beat in the same cycle; beats past the burst length are dropped.
  assign beat_ok  = (state_q == ST_BUSY) && init_done_i && data_beat_i && (beat_cnt_q < len_q)
                    && (op_q == OP_WR || op_q == OP_RD);
  assign wr_ack_o = beat_ok && (op_q == OP_WR);
  assign rd_ack_o = beat_ok && (op_q == OP_RD);

  assign cmd_valid_o = valid_q;
  assign cmd_op_o    = op_q;
  assign cmd_addr_o  = addr_q;
  assign cmd_len_o   = len_q;

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Directed bench for sdram_cmd_arbiter with a cycle-level reference model
// and a per-cycle compare process.
`timescale 1ns/1ps
module tb_sdram_cmd_arbiter;
  import sdram_arb_pkg::*;

  localparam int ADDR_W     = 24;
  localparam int LEN_W      = 10;
  localparam int MAX_BURST  = 512;
  localparam int REF_CYCLES = 781;
`ifdef SDRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk_ref = 1'b0;
  logic              rst_n   = 1'b1;
  logic              init_done = 1'b0;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [LEN_W-1:0]  wr_len = '0;
  logic              wr_ack;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [LEN_W-1:0]  rd_len = '0;
  logic              rd_ack;
  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_ready = 1'b0;
  logic              data_beat = 1'b0;
  logic              cmd_done = 1'b0;
  logic              ref_overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk_ref = ~clk_ref;

  sdram_cmd_arbiter #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_BURST(MAX_BURST), .REF_CYCLES(REF_CYCLES)
  ) dut (
    .clk_ref(clk_ref), .rst_n(rst_n), .init_done_i(init_done),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_len_i(wr_len), .wr_ack_o(wr_ack),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_len_i(rd_len), .rd_ack_o(rd_ack),
    .cmd_valid_o(cmd_valid), .cmd_op_o(cmd_op), .cmd_addr_o(cmd_addr), .cmd_len_o(cmd_len),
    .cmd_ready_i(cmd_ready), .data_beat_i(data_beat), .cmd_done_i(cmd_done),
    .ref_overrun_o(ref_overrun)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 nothing outstanding, 1 command offered, 2 data transfer running
  int                m_phase = 0;
  int                m_op = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  int                m_len = 0;
  int                m_left = 0;
  int                m_run = 0;
  bit                m_pend = 1'b0;
  bit                m_ovr = 1'b0;
  bit                m_last_rd = 1'b1;

  function automatic bit exp_beat();
    return (m_phase == 2) && init_done && data_beat && (m_left > 0);
  endfunction

  task automatic model_step();
    bit gref, wrap, wr_el, rd_el, take_rd;
    int req_len;
    if (!rst_n) begin
      m_phase = 0; m_op = 0; m_addr = '0; m_len = 0; m_left = 0;
      m_run = 0; m_pend = 1'b0; m_ovr = 1'b0; m_last_rd = 1'b1;
    end else if (!init_done) begin
      m_phase = 0; m_op = 0; m_run = 0; m_pend = 1'b0;
    end else begin
      gref = 1'b0;
      case (m_phase)
        0: begin
          wr_el = wr_req && (wr_len != 0);
          rd_el = rd_req && (rd_len != 0);
          if (m_pend) begin
            gref = 1'b1; m_phase = 1; m_op = 3; m_addr = '0; m_len = 0;
          end else if (wr_el || rd_el) begin
            take_rd = !wr_el || (RR && rd_el && !m_last_rd);
            req_len = take_rd ? int'(rd_len) : int'(wr_len);
            m_phase = 1;
            m_op    = take_rd ? 2 : 1;
            m_addr  = take_rd ? rd_addr : wr_addr;
            m_len   = (req_len > MAX_BURST) ? MAX_BURST : req_len;
            m_last_rd = take_rd;
          end
        end
        1: if (cmd_ready) begin m_phase = 2; m_left = m_len; end
        default: begin
          if (exp_beat()) m_left--;
          if (cmd_done) begin m_phase = 0; m_op = 0; end
        end
      endcase
      m_run++;
      wrap = (m_run % REF_CYCLES) == 0;
      if (wrap && m_pend && !gref) m_ovr = 1'b1;
      if (wrap) m_pend = 1'b1;
      else if (gref) m_pend = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk_ref or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk_ref);
    check("cmd_valid", cmd_valid, m_phase == 1);
    check("cmd_op", cmd_op, m_op);
    if (m_phase != 0) begin
      check("cmd_addr", cmd_addr, m_addr);
      check("cmd_len", cmd_len, m_len);
    end
    check("wr_ack", wr_ack, exp_beat() && m_op == 1);
    check("rd_ack", rd_ack, exp_beat() && m_op == 2);
    check("ref_overrun", ref_overrun, m_ovr);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk_ref);
    #1;
  endtask

  task automatic restart();
    init_done = 1'b0;
    tick();
    init_done = 1'b1;
  endtask

  task automatic serve(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                       input logic [LEN_W-1:0] len, input int beats, output int acks);
    int waited = 0;
    acks = 0;
    while (!cmd_valid && waited < 2000) begin tick(); waited++; end
    check("grant_seen", cmd_valid, 1'b1);
    check("grant_op", cmd_op, op);
    check("grant_addr", cmd_addr, addr);
    check("grant_len", cmd_len, len);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    for (int i = 0; i < beats; i++) begin
      data_beat = 1'b1;
      #1;
      if (wr_ack || rd_ack) acks++;
      tick();
    end
    data_beat = 1'b0;
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
  endtask

  initial begin
    int  n, k;
    bit  seen, stable;
    logic [1:0]        op0;
    logic [ADDR_W-1:0] addr0;
    logic [LEN_W-1:0]  len0;

    // Reset and init_done held low
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_valid", cmd_valid, 1'b0);
    check("rst_op", cmd_op, 2'b00);
    check("rst_overrun", ref_overrun, 1'b0);
    check("rst_acks", {wr_ack, rd_ack}, 2'b00);
    rst_n = 1'b1;
    wr_req = 1'b1; wr_addr = 24'h000100; wr_len = 10'd256;
    seen = 1'b0;
    repeat (2000) begin
      tick();
      if (cmd_valid || cmd_op != 2'b00 || wr_ack || rd_ack || ref_overrun) seen = 1'b1;
    end
    check("init_low_quiet", seen, 1'b0);

    // Single 256-word write, engine overdrives 260 beats
    init_done = 1'b1;
    serve(OP_WR, 24'h000100, 10'd256, 260, n);
    check("wr_ack_count", n, 256);
    check("idle_after_done", cmd_op, 2'b00);
    wr_req = 1'b0;
    tick();
    check("no_regrant", cmd_valid, 1'b0);

    // Refresh due while both data requesters wait
    restart();
    repeat (REF_CYCLES) tick();
    wr_req = 1'b1; wr_addr = 24'h000200; wr_len = 10'd4;
    rd_req = 1'b1; rd_addr = 24'h000300; rd_len = 10'd4;
    serve(OP_REF, '0, '0, 0, n);
    check("ref_no_ack", n, 0);
    serve(OP_WR, 24'h000200, 10'd4, 4, n);
    check("tie1_acks", n, 4);
    if (RR) serve(OP_RD, 24'h000300, 10'd4, 4, n);
    else    serve(OP_WR, 24'h000200, 10'd4, 4, n);
    check("tie2_acks", n, 4);
    serve(OP_WR, 24'h000200, 10'd4, 4, n);
    check("tie3_acks", n, 4);
    wr_req = 1'b0; rd_req = 1'b0;

    // Engine stalls 1600 cycles: command stable, overrun on second wrap
    restart();
    wr_req = 1'b1; wr_addr = 24'hABCDEF; wr_len = 10'd16;
    k = 0;
    while (!cmd_valid && k < 50) begin tick(); k++; end
    check("stall_grant", cmd_valid, 1'b1);
    op0 = cmd_op; addr0 = cmd_addr; len0 = cmd_len;
    stable = 1'b1;
    for (int i = 0; i < 1600; i++) begin
      tick();
      if (!cmd_valid || cmd_op != op0 || cmd_addr != addr0 || cmd_len != len0) stable = 1'b0;
      if (i == 1000) check("overrun_after_first_wrap", ref_overrun, 1'b0);
    end
    check("stall_stable", stable, 1'b1);
    check("overrun_after_second_wrap", ref_overrun, 1'b1);
    serve(OP_WR, 24'hABCDEF, 10'd16, 16, n);
    wr_req = 1'b0;
    check("stall_acks", n, 16);
    serve(OP_REF, '0, '0, 0, n);
    check("overrun_sticky", ref_overrun, 1'b1);

    // Zero-length requests and clamping
    restart();
    rd_req = 1'b1; rd_addr = 24'h000300; rd_len = 10'd0;
    seen = 1'b0;
    repeat (50) begin tick(); if (cmd_valid) seen = 1'b1; end
    check("len0_no_cmd", seen, 1'b0);
    wr_req = 1'b1; wr_addr = 24'h000777; wr_len = 10'd0; rd_len = 10'd5;
    serve(OP_RD, 24'h000300, 10'd5, 5, n);
    check("len0_wr_yields", n, 5);
    wr_req = 1'b0; rd_addr = 24'h000400; rd_len = 10'd1000;
    serve(OP_RD, 24'h000400, 10'd512, 520, n);
    check("clamp_rd_acks", n, 512);
    rd_req = 1'b0;

    // init_done dropped mid-burst
    restart();
    wr_req = 1'b1; wr_addr = 24'h005000; wr_len = 10'd100;
    k = 0;
    while (!cmd_valid && k < 50) begin tick(); k++; end
    check("abort_grant", cmd_valid, 1'b1);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      data_beat = 1'b1;
      #1;
      if (wr_ack) n++;
      tick();
    end
    check("abort_beats", n, 10);
    init_done = 1'b0; wr_req = 1'b0;
    #1;
    check("abort_ack_off", wr_ack, 1'b0);
    tick();
    check("abort_idle_op", cmd_op, 2'b00);
    check("abort_idle_valid", cmd_valid, 1'b0);
    data_beat = 1'b0;
    init_done = 1'b1;
    k = 0;
    while (!cmd_valid && k < 2000) begin tick(); k++; end
    check("timer_restart_latency", k, REF_CYCLES + 1);
    check("timer_restart_op", cmd_op, OP_REF);
    serve(OP_REF, '0, '0, 0, n);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
